ls_queue: RTL and testbench
===========================

LS_QUEUE -- requirements
Module: ls_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of queue entries (power of 2, >=2).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 flush  in  1  mispredict squash; empties queue.
REQ-005 dp_en  in  1  dispatch valid, one load/store per cycle, program order.
REQ-006 dp_read_write  in  1  1=load, 0=store.
REQ-007 dp_func3  in  3  memory size/sign code.
REQ-008 dp_imm  in  XLEN  address offset.
REQ-009 dp_tag  in  ROB_TAG_LEN  ROB tag of the instruction.
REQ-010 dp_src1_ready / dp_src1_value / dp_src1_tag  in  1/XLEN/ROB_TAG_LEN  base operand, or producer tag if not ready.
REQ-011 dp_src2_ready / dp_src2_value / dp_src2_tag  in  1/XLEN/ROB_TAG_LEN  store data operand (ignored for loads).
REQ-012 cdb_valid / cdb_tag / cdb_value  in  1/ROB_TAG_LEN/XLEN  result broadcast.
REQ-013 rob_head_tag  in  ROB_TAG_LEN  tag at ROB head (store commit point).
REQ-014 fu_done  in  1  memory unit completed the issued head op this cycle.
REQ-015 issue_en  out  1  head op valid and issuable to memory unit.
REQ-016 issue_read_write / issue_func3 / issue_src1 / issue_src2 / issue_imm / issue_tag  out  1/3/XLEN/XLEN/XLEN/ROB_TAG_LEN  head entry fields.
REQ-017 full  out  1  count == DEPTH.
REQ-018 count  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-019 Queue SHALL be circular FIFO; head/tail pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
REQ-020 dp_en && !full && !flush SHALL write entry at tail, advance tail, increment count next cycle.
REQ-021 dp_en while full SHALL be dropped, even if head pops the same cycle; no state change from it.
REQ-022 Each cycle cdb_valid SHALL set ready and capture cdb_value in every valid entry whose unready src tag equals cdb_tag (src1 and src2 independently).
REQ-023 Dispatch with unready src whose tag equals cdb_tag in the same cycle SHALL store that src ready with cdb_value.
REQ-024 issue_en SHALL be combinational from registered head entry: valid && src1 ready && (load, or store && src2 ready && issue_tag == rob_head_tag).
REQ-025 Only head entry SHALL issue; no reordering, loads never bypass older stores.
REQ-026 issue_* fields SHALL hold steady while issue_en stays high and fu_done is low (memory miss stall).
REQ-027 fu_done && issue_en SHALL pop head: invalidate, advance head, decrement count next cycle; fu_done without issue_en ignored.
REQ-028 Simultaneous accepted dispatch and pop SHALL leave count unchanged and move both pointers.
REQ-029 CDB capture SHALL apply to the head entry even in the cycle it is popped (no effect after pop).
REQ-030 flush SHALL, next cycle, invalidate all entries, zero head, tail, count; overrides dispatch, pop and CDB capture.
REQ-031 Empty queue SHALL drive issue_en=0; issue_* fields are don't-care but SHALL be zero when empty.

Reset
REQ-032 reset_n low at posedge clk SHALL invalidate all entries and set head=tail=0, count=0, full=0, issue_en=0, issue_*=0.
REQ-033 Reset SHALL take priority over flush, dispatch, pop and CDB; mid-stall reset drops the in-flight op without completion.

Verification
REQ-034 Load with src1 ready value 0x100, imm 0x4, tag 3 dispatched -> next cycle issue_en=1, issue_src1=0x100, issue_imm=0x4; fu_done -> count 1->0, issue_en=0.
REQ-035 Store tag 5, src2 waiting tag 7, rob_head_tag=5 -> issue_en=0; cdb_valid tag 7 value 0xDEAD -> next cycle issue_en=1, issue_src2=0xDEAD; rob_head_tag changed to 4 -> issue_en=0.
REQ-036 Fill DEPTH=8 entries -> full=1, count=8; 9th dp_en with simultaneous pop dropped -> count=7; continue 20 push/pop cycles -> order preserved across wrap.
REQ-037 Head load issued, fu_done low 3 cycles -> issue_* stable 3 cycles; fu_done high cycle 4 -> next entry presented cycle 5.
REQ-038 4 entries, flush with simultaneous dp_en and fu_done -> next cycle count=0, issue_en=0, full=0.
REQ-039 reset_n low during stall with 3 entries -> next cycle count=0, issue_en=0, all outputs zero.

Source files
------------

// File: rtl/ls_queue.sv
// ls_queue: in-order load/store queue sitting between dispatch and the
// memory unit. It holds DEPTH entries in a circular FIFO, captures operand
// values from the common data bus, and presents only the oldest entry
// to the memory unit.
//
// Ports
//   clk, reset_n          single clock, synchronous active-low reset
//   flush                 squash on mispredict; the queue is empty next cycle
//   dp_*                  dispatch of one load (dp_read_write=1) or store per cycle
//   cdb_*                 result broadcast used to wake up waiting operands
//   rob_head_tag          a store may issue only when it is at the ROB head
//   fu_done               memory unit finished the issued head op
//   issue_en, issue_*     head entry presented to the memory unit
//   full, count           occupancy
module ls_queue #(
   parameter int DEPTH       = 8,
   parameter int XLEN        = 32,
   parameter int ROB_TAG_LEN = 6
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         flush,
   input  logic                         dp_en,
   input  logic                         dp_read_write,
   input  logic [2:0]                   dp_func3,
   input  logic [XLEN-1:0]              dp_imm,
   input  logic [ROB_TAG_LEN-1:0]       dp_tag,
   input  logic                         dp_src1_ready,
   input  logic [XLEN-1:0]              dp_src1_value,
   input  logic [ROB_TAG_LEN-1:0]       dp_src1_tag,
   input  logic                         dp_src2_ready,
   input  logic [XLEN-1:0]              dp_src2_value,
   input  logic [ROB_TAG_LEN-1:0]       dp_src2_tag,
   input  logic                         cdb_valid,
   input  logic [ROB_TAG_LEN-1:0]       cdb_tag,
   input  logic [XLEN-1:0]              cdb_value,
   input  logic [ROB_TAG_LEN-1:0]       rob_head_tag,
   input  logic                         fu_done,
   output logic                         issue_en,
   output logic                         issue_read_write,
   output logic [2:0]                   issue_func3,
   output logic [XLEN-1:0]              issue_src1,
   output logic [XLEN-1:0]              issue_src2,
   output logic [XLEN-1:0]              issue_imm,
   output logic [ROB_TAG_LEN-1:0]       issue_tag,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   // Control state (reset and flushed)
   logic [DEPTH-1:0] valid;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;

   // Entry payload (never reset; meaningful only while valid)
   logic                   rw_q     [DEPTH];
   logic [2:0]             func3_q  [DEPTH];
   logic [XLEN-1:0]        imm_q    [DEPTH];
   logic [ROB_TAG_LEN-1:0] tag_q    [DEPTH];
   logic                   s1_rdy_q [DEPTH];
   logic [XLEN-1:0]        s1_val_q [DEPTH];
   logic [ROB_TAG_LEN-1:0] s1_tag_q [DEPTH];
   logic                   s2_rdy_q [DEPTH];
   logic [XLEN-1:0]        s2_val_q [DEPTH];
   logic [ROB_TAG_LEN-1:0] s2_tag_q [DEPTH];

   logic            push;
   logic            pop;
   logic            s1_rdy_in;
   logic            s2_rdy_in;
   logic [XLEN-1:0] s1_val_in;
   logic [XLEN-1:0] s2_val_in;

   // Stores wait for the ROB head so memory is only written once the store
   // is non-speculative; loads go as soon as their base is known. Because
   // only the head may issue, a load can never pass an older store.
   assign issue_en = valid[head] && s1_rdy_q[head] &&
                     (rw_q[head] || (s2_rdy_q[head] && (tag_q[head] == rob_head_tag)));

   assign full = (count == CNT_W'(DEPTH));
   // A full queue drops dispatch even if the head pops in the same cycle.
   assign push = dp_en && !full && !flush;
   assign pop  = fu_done && issue_en && !flush;

   // Operand arriving on the CDB in the dispatch cycle is taken directly.
   assign s1_rdy_in = dp_src1_ready || (cdb_valid && (dp_src1_tag == cdb_tag));
   assign s1_val_in = dp_src1_ready ? dp_src1_value : cdb_value;
   assign s2_rdy_in = dp_src2_ready || (cdb_valid && (dp_src2_tag == cdb_tag));
   assign s2_val_in = dp_src2_ready ? dp_src2_value : cdb_value;

   always_comb begin
      issue_read_write = 1'b0;
      issue_func3      = '0;
      issue_src1       = '0;
      issue_src2       = '0;
      issue_imm        = '0;
      issue_tag        = '0;
      if (valid[head]) begin
         issue_read_write = rw_q[head];
         issue_func3      = func3_q[head];
         issue_src1       = s1_val_q[head];
         issue_src2       = s2_val_q[head];
         issue_imm        = imm_q[head];
         issue_tag        = tag_q[head];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         valid <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         // push and pop never target the same slot: pop needs a valid head,
         // push needs a free tail, and head==tail means empty or full.
         if (pop) begin
            valid[head] <= 1'b0;
            head        <= head + PTR_W'(1);
         end
         if (push) begin
            valid[tail] <= 1'b1;
            tail        <= tail + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      // Wake-up applies to every valid entry, including a head popping now;
      // the captured value simply dies with the popped entry.
      for (int i = 0; i < DEPTH; i++) begin
         if (cdb_valid && valid[i]) begin
            if (!s1_rdy_q[i] && (s1_tag_q[i] == cdb_tag)) begin
               s1_rdy_q[i] <= 1'b1;
               s1_val_q[i] <= cdb_value;
            end
            if (!s2_rdy_q[i] && (s2_tag_q[i] == cdb_tag)) begin
               s2_rdy_q[i] <= 1'b1;
               s2_val_q[i] <= cdb_value;
            end
         end
      end
      if (push) begin
         rw_q[tail]     <= dp_read_write;
         func3_q[tail]  <= dp_func3;
         imm_q[tail]    <= dp_imm;
         tag_q[tail]    <= dp_tag;
         s1_rdy_q[tail] <= s1_rdy_in;
         s1_val_q[tail] <= s1_val_in;
         s1_tag_q[tail] <= dp_src1_tag;
         s2_rdy_q[tail] <= s2_rdy_in;
         s2_val_q[tail] <= s2_val_in;
         s2_tag_q[tail] <= dp_src2_tag;
      end
   end

endmodule

// File: tb/tb_ls_queue.sv
// Bench for ls_queue: directed scenarios followed by randomized traffic.
// A queue-based reference model predicts occupancy and the head entry each
// cycle; completed memory ops are checked by a separate monitor against a
// scoreboard filled at dispatch time.
module tb_ls_queue;
   localparam int DEPTH = 8;
   localparam int XLEN  = 32;
   localparam int TL    = 6;
   localparam int CW    = $clog2(DEPTH+1);

   logic            clk = 1'b0;
   logic            reset_n, flush, dp_en, dp_read_write;
   logic [2:0]      dp_func3;
   logic [XLEN-1:0] dp_imm, dp_src1_value, dp_src2_value, cdb_value;
   logic [TL-1:0]   dp_tag, dp_src1_tag, dp_src2_tag, cdb_tag, rob_head_tag;
   logic            dp_src1_ready, dp_src2_ready, cdb_valid, fu_done;
   logic            issue_en, issue_read_write, full;
   logic [2:0]      issue_func3;
   logic [XLEN-1:0] issue_src1, issue_src2, issue_imm;
   logic [TL-1:0]   issue_tag;
   logic [CW-1:0]   count;

   ls_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_TAG_LEN(TL)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .dp_en(dp_en), .dp_read_write(dp_read_write), .dp_func3(dp_func3),
      .dp_imm(dp_imm), .dp_tag(dp_tag),
      .dp_src1_ready(dp_src1_ready), .dp_src1_value(dp_src1_value), .dp_src1_tag(dp_src1_tag),
      .dp_src2_ready(dp_src2_ready), .dp_src2_value(dp_src2_value), .dp_src2_tag(dp_src2_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .rob_head_tag(rob_head_tag), .fu_done(fu_done),
      .issue_en(issue_en), .issue_read_write(issue_read_write), .issue_func3(issue_func3),
      .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_imm(issue_imm),
      .issue_tag(issue_tag), .full(full), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            rw;
      logic [2:0]      f3;
      logic [XLEN-1:0] imm;
      logic [TL-1:0]   tag;
      logic            r1;
      logic [XLEN-1:0] v1;   // final operand value once ready
      logic [TL-1:0]   t1;
      logic            r2;
      logic [XLEN-1:0] v2;
      logic [TL-1:0]   t2;
   } ent_t;

   ent_t            mq[$];      // reference model: oldest entry first
   ent_t            exp_q[$];   // scoreboard of expected completions
   logic [XLEN-1:0] tag_val [0:(1<<TL)-1];  // value each producer tag broadcasts
   int              total = 0;
   int              bad = 0;
   bit              started = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_issue();
      if (mq.size() == 0) return 1'b0;
      return mq[0].r1 && (mq[0].rw || (mq[0].r2 && mq[0].tag == rob_head_tag));
   endfunction

   // Called at posedge+2 with inputs set: check outputs mid-cycle, advance
   // the model across the next edge, then return at posedge+2 with pulses cleared.
   task automatic go();
      ent_t e;
      logic pop_m, full_m;
      @(negedge clk);
      chk("count", 64'(count), 64'(mq.size()));
      chk("full", 64'(full), 64'(mq.size() == DEPTH));
      chk("issue_en", 64'(issue_en), 64'(model_issue()));
      if (mq.size() == 0) begin
         chk("empty_zero", 64'(|{issue_read_write, issue_func3, issue_src1, issue_src2,
                                 issue_imm, issue_tag}), 64'd0);
      end else begin
         chk("head_tag", 64'(issue_tag), 64'(mq[0].tag));
         chk("head_ctl", 64'({issue_read_write, issue_func3}), 64'({mq[0].rw, mq[0].f3}));
         chk("head_imm", 64'(issue_imm), 64'(mq[0].imm));
         if (mq[0].r1) chk("head_src1", 64'(issue_src1), 64'(mq[0].v1));
         if (!mq[0].rw && mq[0].r2) chk("head_src2", 64'(issue_src2), 64'(mq[0].v2));
      end
      #1;
      if (!reset_n || flush) begin
         mq.delete();
         exp_q.delete();
      end else begin
         pop_m  = fu_done && model_issue();
         full_m = (mq.size() == DEPTH);
         if (cdb_valid) begin
            foreach (mq[i]) begin
               if (!mq[i].r1 && mq[i].t1 == cdb_tag) mq[i].r1 = 1'b1;
               if (!mq[i].r2 && mq[i].t2 == cdb_tag) mq[i].r2 = 1'b1;
            end
         end
         if (pop_m) void'(mq.pop_front());
         if (dp_en && !full_m) begin
            e.rw  = dp_read_write;
            e.f3  = dp_func3;
            e.imm = dp_imm;
            e.tag = dp_tag;
            e.t1  = dp_src1_tag;
            e.t2  = dp_src2_tag;
            e.r1  = dp_src1_ready || (cdb_valid && dp_src1_tag == cdb_tag);
            e.r2  = dp_src2_ready || (cdb_valid && dp_src2_tag == cdb_tag);
            e.v1  = dp_src1_ready ? dp_src1_value : tag_val[dp_src1_tag];
            e.v2  = dp_src2_ready ? dp_src2_value : tag_val[dp_src2_tag];
            mq.push_back(e);
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      #2;
      dp_en = 1'b0; cdb_valid = 1'b0; fu_done = 1'b0; flush = 1'b0; reset_n = 1'b1;
   endtask

   // Completion monitor: each real pop must match the oldest dispatched op.
   always @(negedge clk) begin
      ent_t m;
      if (started && reset_n && !flush && issue_en && fu_done) begin
         if (exp_q.size() == 0) begin
            chk("pop_unexpected", 64'd1, 64'd0);
         end else begin
            m = exp_q.pop_front();
            chk("pop_tag", 64'(issue_tag), 64'(m.tag));
            chk("pop_imm", 64'(issue_imm), 64'(m.imm));
            chk("pop_src1", 64'(issue_src1), 64'(m.v1));
            if (!m.rw) chk("pop_src2", 64'(issue_src2), 64'(m.v2));
         end
      end
   end

   task automatic set_load(input logic [TL-1:0] t, input logic [XLEN-1:0] v, input logic [XLEN-1:0] imm);
      dp_en = 1'b1; dp_read_write = 1'b1; dp_func3 = 3'b010; dp_imm = imm; dp_tag = t;
      dp_src1_ready = 1'b1; dp_src1_value = v; dp_src1_tag = '0;
      dp_src2_ready = 1'b1; dp_src2_value = '0; dp_src2_tag = '0;
   endtask

   task automatic set_cdb(input logic [TL-1:0] t);
      cdb_valid = 1'b1; cdb_tag = t; cdb_value = tag_val[t];
   endtask

   task automatic drain();
      for (int k = 0; k < 2*DEPTH && mq.size() > 0; k++) begin
         rob_head_tag = mq[0].tag;
         fu_done = 1'b1;
         go();
      end
   endtask

   task automatic rand_cycle(input int p_dp, input int p_fd, input int p_fl, input int p_rst);
      dp_en         = ($urandom_range(99) < p_dp);
      dp_read_write = 1'($urandom);
      dp_func3      = 3'($urandom);
      dp_imm        = $urandom;
      dp_tag        = TL'($urandom);
      dp_src1_ready = ($urandom_range(99) < 60);
      dp_src1_value = $urandom;
      dp_src1_tag   = TL'($urandom_range(7));
      dp_src2_ready = ($urandom_range(99) < 60);
      dp_src2_value = $urandom;
      dp_src2_tag   = TL'($urandom_range(7));
      if ($urandom_range(99) < 40) set_cdb(TL'($urandom_range(7)));
      rob_head_tag  = (mq.size() > 0 && $urandom_range(3) != 0) ? mq[0].tag : TL'($urandom);
      fu_done       = ($urandom_range(99) < p_fd);
      flush         = ($urandom_range(999) < p_fl);
      reset_n       = !($urandom_range(999) < p_rst);
      go();
   endtask

   initial begin
      logic [TL-1:0] held_tag;
      for (int i = 0; i < (1 << TL); i++) tag_val[i] = $urandom;
      tag_val[7] = 32'hDEAD;
      reset_n = 1'b0; flush = 1'b0; dp_en = 1'b0; dp_read_write = 1'b0; dp_func3 = '0;
      dp_imm = '0; dp_tag = '0; dp_src1_ready = 1'b0; dp_src1_value = '0; dp_src1_tag = '0;
      dp_src2_ready = 1'b0; dp_src2_value = '0; dp_src2_tag = '0; cdb_valid = 1'b0;
      cdb_tag = '0; cdb_value = '0; rob_head_tag = '0; fu_done = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      started = 1;
      go();                                   // reset state checked here

      // Load with ready base issues next cycle and pops on fu_done
      set_load(TL'(3), 32'h100, 32'h4);
      go();
      chk("d_load_en", 64'(issue_en), 64'd1);
      chk("d_load_src1", 64'(issue_src1), 64'h100);
      chk("d_load_imm", 64'(issue_imm), 64'h4);
      chk("d_load_cnt", 64'(count), 64'd1);
      fu_done = 1'b1;
      go();
      chk("d_pop_cnt", 64'(count), 64'd0);
      chk("d_pop_en", 64'(issue_en), 64'd0);

      // Store waits on src2 producer tag 7, then on the ROB head
      dp_en = 1'b1; dp_read_write = 1'b0; dp_func3 = 3'b010; dp_imm = 32'h8; dp_tag = TL'(5);
      dp_src1_ready = 1'b1; dp_src1_value = 32'h200; dp_src2_ready = 1'b0; dp_src2_tag = TL'(7);
      rob_head_tag = TL'(5);
      go();
      chk("d_st_wait", 64'(issue_en), 64'd0);
      set_cdb(TL'(7));
      go();
      chk("d_st_en", 64'(issue_en), 64'd1);
      chk("d_st_src2", 64'(issue_src2), 64'hDEAD);
      rob_head_tag = TL'(4);
      #1;
      chk("d_st_robhead", 64'(issue_en), 64'd0);
      drain();

      // Fill, drop the 9th dispatch during a pop, then stream across wrap
      for (int i = 0; i < DEPTH; i++) begin
         set_load(TL'(i + 16), $urandom, $urandom);
         go();
      end
      chk("d_full", 64'(full), 64'd1);
      chk("d_full_cnt", 64'(count), 64'(DEPTH));
      set_load(TL'(40), $urandom, $urandom);
      fu_done = 1'b1;
      go();
      chk("d_drop_cnt", 64'(count), 64'(DEPTH - 1));
      for (int i = 0; i < 20; i++) begin
         set_load(TL'(i + 41), $urandom, $urandom);
         fu_done = 1'b1;
         go();
      end
      drain();

      // Memory-miss stall holds the head, then the next entry appears
      set_load(TL'(10), 32'hAAAA, 32'h10);
      go();
      set_load(TL'(11), 32'hBBBB, 32'h14);
      go();
      for (int i = 0; i < 3; i++) begin
         go();
         chk("d_stall_tag", 64'(issue_tag), 64'd10);
         chk("d_stall_src1", 64'(issue_src1), 64'hAAAA);
      end
      fu_done = 1'b1;
      go();
      chk("d_next_tag", 64'(issue_tag), 64'd11);
      drain();

      // Flush beats simultaneous dispatch and pop
      for (int i = 0; i < 4; i++) begin
         set_load(TL'(i + 20), $urandom, $urandom);
         go();
      end
      set_load(TL'(30), $urandom, $urandom);
      fu_done = 1'b1;
      flush = 1'b1;
      go();
      chk("d_flush_cnt", 64'(count), 64'd0);
      chk("d_flush_en", 64'(issue_en), 64'd0);
      chk("d_flush_full", 64'(full), 64'd0);

      // Reset during a stall drops everything
      for (int i = 0; i < 3; i++) begin
         set_load(TL'(i + 24), $urandom, $urandom);
         go();
      end
      held_tag = issue_tag;
      chk("d_pre_rst_tag", 64'(held_tag), 64'd24);
      reset_n = 1'b0;
      go();
      chk("d_rst_cnt", 64'(count), 64'd0);
      chk("d_rst_en", 64'(issue_en), 64'd0);
      chk("d_rst_zero", 64'(|{issue_src1, issue_src2, issue_imm, issue_tag, full}), 64'd0);

      // Randomized traffic: filling, draining, then mixed with flush/reset
      for (int i = 0; i < 600; i++) rand_cycle(75, 20, 0, 0);
      for (int i = 0; i < 600; i++) rand_cycle(35, 75, 0, 0);
      for (int i = 0; i < 1200; i++) rand_cycle(60, 50, 15, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
